// File: rtl/adc_test_sequencer_pkg.sv
// Shared types and constants for the ADC characterisation sequencer.
// Optional feature macro used by the top: ADC_MEAN_ROUND_EN.
package adc_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_STORE,
    ST_DONE
  } state_t;

  typedef logic [2:0] phase_t;

  localparam phase_t NUM_PHASES = 3'd5;
  localparam phase_t PH_VDD     = 3'd2;
  localparam phase_t PH_GND     = 3'd4;

  localparam int ADC_W  = 14;
  localparam int MEAN_W = 16;
  localparam int NUM_CH = 4;

  // Channels driven to VDD while in the given phase.
  function automatic logic [NUM_CH-1:0] vdd_pattern(phase_t ph, logic [NUM_CH-1:0] mask);
    return (ph == PH_VDD) ? mask : '0;
  endfunction

  // Channels driven to GND while in the given phase.
  function automatic logic [NUM_CH-1:0] gnd_pattern(phase_t ph, logic [NUM_CH-1:0] mask);
    return (ph == PH_GND) ? mask : '0;
  endfunction

endpackage

// File: rtl/adc_test_sequencer_if.sv
// Host/ADC-facing signal bundle of the ADC test sequencer.
// master = host register block + ADC macro, slave = the sequencer.
interface adc_test_sequencer_if;
  import adc_test_pkg::*;

  logic              we;
  logic [ADC_W-1:0]  bn;
  logic [NUM_CH-1:0] trigger_sel;
  logic              one_shot;
  logic              adc_clk;
  logic              end_flag;
  logic              trigger_vdd_0, trigger_vdd_1, trigger_vdd_2, trigger_vdd_3;
  logic              trigger_gnd_0, trigger_gnd_1, trigger_gnd_2, trigger_gnd_3;
  logic [MEAN_W-1:0] mean_s1, mean_s2, mean_s3, mean_s4, mean_s5;

  modport master (
    output we, bn, trigger_sel, one_shot,
    input  adc_clk, end_flag,
    input  trigger_vdd_0, trigger_vdd_1, trigger_vdd_2, trigger_vdd_3,
    input  trigger_gnd_0, trigger_gnd_1, trigger_gnd_2, trigger_gnd_3,
    input  mean_s1, mean_s2, mean_s3, mean_s4, mean_s5
  );

  modport slave (
    input  we, bn, trigger_sel, one_shot,
    output adc_clk, end_flag,
    output trigger_vdd_0, trigger_vdd_1, trigger_vdd_2, trigger_vdd_3,
    output trigger_gnd_0, trigger_gnd_1, trigger_gnd_2, trigger_gnd_3,
    output mean_s1, mean_s2, mean_s3, mean_s4, mean_s5
  );

endinterface

// File: rtl/adc_test_sequencer_clk_div.sv
// ADC sampling clock divider: adc_clk toggles every CLK_DIV clk cycles and
// strobe_o is high for the single clk cycle in which adc_clk has just risen.
module adc_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic adc_clk_o,
  output logic strobe_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       adc_clk_q, adc_clk_d;
  logic       strobe_q, strobe_d;

  // Next-state: count to CLK_DIV, then toggle; flag the 0->1 transition.
  always_comb begin
    cnt_d     = cnt_q + 8'd1;
    adc_clk_d = adc_clk_q;
    strobe_d  = 1'b0;
    if (cnt_q == DIV_LAST) begin
      cnt_d     = '0;
      adc_clk_d = ~adc_clk_q;
      strobe_d  = ~adc_clk_q;
    end
  end

  // Divider registers; free-running once reset is released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      adc_clk_q <= 1'b0;
      strobe_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      adc_clk_q <= adc_clk_d;
      strobe_q  <= strobe_d;
    end
  end

  assign adc_clk_o = adc_clk_q;
  assign strobe_o  = strobe_q;

endmodule

// File: rtl/adc_test_sequencer.sv
// ADC characterisation sequencer: runs five test phases, each discarding
// SETTLE strobes then averaging 2^SAMPLES_LOG2 codes, with per-phase
// VDD/GND trigger patterns. Macro ADC_MEAN_ROUND_EN selects round-half-up
// averaging instead of truncation.
module adc_test_sequencer
  import adc_test_pkg::*;
#(
  parameter int CLK_DIV      = 4,
  parameter int SAMPLES_LOG2 = 4,
  parameter int SETTLE       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_test_sequencer_if.slave  bus
);

  // One spare bit so the rounding offset can never overflow the sum.
  localparam int ACC_W = ADC_W + SAMPLES_LOG2 + 1;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [8:0] SAMP_LAST   = 9'((1 << SAMPLES_LOG2) - 1);

`ifdef ADC_MEAN_ROUND_EN
  localparam logic [ACC_W-1:0] RND = (SAMPLES_LOG2 == 0) ? '0 :
                                     (ACC_W'(1) << (SAMPLES_LOG2 - 1));
`else
  localparam logic [ACC_W-1:0] RND = '0;
`endif

  logic strobe;

  state_t            state_q, state_d;
  phase_t            phase_q, phase_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [7:0]        settle_q, settle_d;
  logic [8:0]        samp_q, samp_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [NUM_CH-1:0] vdd_q, vdd_d;
  logic [NUM_CH-1:0] gnd_q, gnd_d;
  logic              end_q, end_d;
  logic              hold_q, hold_d;
  logic              store_en;
  logic [ACC_W-1:0]  rounded;
  logic [MEAN_W-1:0] store_val;
  logic [MEAN_W-1:0] mean_q [NUM_PHASES];

  adc_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .adc_clk_o (bus.adc_clk),
    .strobe_o  (strobe)
  );

  assign rounded   = acc_q + RND;
  assign store_val = MEAN_W'(rounded >> SAMPLES_LOG2);

  // Sequencer next-state, counters, accumulator and registered triggers.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    mask_d   = mask_q;
    settle_d = settle_q;
    samp_d   = samp_q;
    acc_d    = acc_q;
    vdd_d    = vdd_q;
    gnd_d    = gnd_q;
    end_d    = end_q;
    hold_d   = hold_q;
    store_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mask_d   = bus.trigger_sel;
        phase_d  = 3'd1;
        settle_d = '0;
        samp_d   = '0;
        acc_d    = '0;
        vdd_d    = '0;
        gnd_d    = '0;
        end_d    = 1'b0;
        state_d  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (SETTLE == 0) begin
          state_d = ST_ACCUM;
        end else if (strobe && bus.we) begin
          if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            state_d  = ST_ACCUM;
          end else begin
            settle_d = settle_q + 8'd1;
          end
        end
      end
      ST_ACCUM: begin
        if (strobe && bus.we) begin
          acc_d = acc_q + ACC_W'(bus.bn);
          if (samp_q == SAMP_LAST) begin
            samp_d  = '0;
            state_d = ST_STORE;
          end else begin
            samp_d = samp_q + 9'd1;
          end
        end
      end
      ST_STORE: begin
        store_en = 1'b1;
        acc_d    = '0;
        if (phase_q == NUM_PHASES) begin
          vdd_d   = '0;
          gnd_d   = '0;
          end_d   = 1'b1;
          hold_d  = bus.one_shot;
          state_d = ST_DONE;
        end else begin
          phase_d = phase_q + 3'd1;
          vdd_d   = vdd_pattern(phase_q + 3'd1, mask_q);
          gnd_d   = gnd_pattern(phase_q + 3'd1, mask_q);
          state_d = ST_SETTLE;
        end
      end
      ST_DONE: begin
        // In one-shot mode stay here with end_flag held until reset.
        if (!hold_q) begin
          end_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= 3'd1;
      mask_q   <= '0;
      settle_q <= '0;
      samp_q   <= '0;
      acc_q    <= '0;
      vdd_q    <= '0;
      gnd_q    <= '0;
      end_q    <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      mask_q   <= mask_d;
      settle_q <= settle_d;
      samp_q   <= samp_d;
      acc_q    <= acc_d;
      vdd_q    <= vdd_d;
      gnd_q    <= gnd_d;
      end_q    <= end_d;
      hold_q   <= hold_d;
    end
  end

  // Each mean register only updates in the STORE of its own phase.
  for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_mean
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mean_q[gi] <= '0;
      end else if (store_en && (phase_q == phase_t'(gi + 1))) begin
        mean_q[gi] <= store_val;
      end
    end
  end

  assign bus.end_flag      = end_q;
  assign bus.trigger_vdd_0 = vdd_q[0];
  assign bus.trigger_vdd_1 = vdd_q[1];
  assign bus.trigger_vdd_2 = vdd_q[2];
  assign bus.trigger_vdd_3 = vdd_q[3];
  assign bus.trigger_gnd_0 = gnd_q[0];
  assign bus.trigger_gnd_1 = gnd_q[1];
  assign bus.trigger_gnd_2 = gnd_q[2];
  assign bus.trigger_gnd_3 = gnd_q[3];
  assign bus.mean_s1       = mean_q[0];
  assign bus.mean_s2       = mean_q[1];
  assign bus.mean_s3       = mean_q[2];
  assign bus.mean_s4       = mean_q[3];
  assign bus.mean_s5       = mean_q[4];

endmodule

// File: tb/tb_adc_test_sequencer.sv
// Bench for adc_test_sequencer (default parameters: CLK_DIV=4,
// SAMPLES_LOG2=4, SETTLE=8). A monitor pops expected means on every
// end_flag rising edge; the stimulus thread pushes them before each run.
module tb_adc_test_sequencer;

  logic clk;
  logic rst;
  logic toggle_en;
  logic alt;
  logic [13:0] bn_val;

  adc_test_sequencer_if bus();

  adc_test_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ADC code: constant, or alternating 100/101 on each adc_clk period.
  always @(negedge bus.adc_clk) alt <= ~alt;
  assign bus.bn = toggle_en ? (alt ? 14'd101 : 14'd100) : bn_val;

  logic [15:0] means [5];
  assign means[0] = bus.mean_s1;
  assign means[1] = bus.mean_s2;
  assign means[2] = bus.mean_s3;
  assign means[3] = bus.mean_s4;
  assign means[4] = bus.mean_s5;

  int n_cmp = 0;
  int n_err = 0;
  logic [79:0] exp_q [$];

  // adc_clk rising edges since the last reset.
  int rise_cnt;
  always @(posedge bus.adc_clk or negedge rst) begin
    if (!rst) rise_cnt <= 0;
    else      rise_cnt <= rise_cnt + 1;
  end

  // Trigger observations since the last reset.
  int cyc, vdd_cycles, gnd_cycles, bad_cycles, any_cycles, first_vdd, first_gnd;
  logic bad_now, any_now;
  assign bad_now = (bus.trigger_vdd_0 && bus.trigger_gnd_0) ||
                   (bus.trigger_vdd_2 && bus.trigger_gnd_2) ||
                   bus.trigger_vdd_1 || bus.trigger_gnd_1 ||
                   bus.trigger_vdd_3 || bus.trigger_gnd_3 ||
                   (bus.trigger_vdd_0 != bus.trigger_vdd_2) ||
                   (bus.trigger_gnd_0 != bus.trigger_gnd_2);
  assign any_now = bus.trigger_vdd_0 | bus.trigger_vdd_1 | bus.trigger_vdd_2 | bus.trigger_vdd_3 |
                   bus.trigger_gnd_0 | bus.trigger_gnd_1 | bus.trigger_gnd_2 | bus.trigger_gnd_3;
  always @(negedge clk) begin
    if (!rst) begin
      cyc <= 0; vdd_cycles <= 0; gnd_cycles <= 0; bad_cycles <= 0;
      any_cycles <= 0; first_vdd <= -1; first_gnd <= -1;
    end else begin
      cyc <= cyc + 1;
      if (bus.trigger_vdd_0) begin
        vdd_cycles <= vdd_cycles + 1;
        if (first_vdd < 0) first_vdd <= cyc;
      end
      if (bus.trigger_gnd_0) begin
        gnd_cycles <= gnd_cycles + 1;
        if (first_gnd < 0) first_gnd <= cyc;
      end
      if (bad_now) bad_cycles <= bad_cycles + 1;
      if (any_now) any_cycles <= any_cycles + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int v);
    exp_q.push_back({5{16'(v)}});
  endtask

  // Scoreboard monitor: compares means each time a sequence completes.
  task automatic monitor();
    logic prev;
    logic [79:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.end_flag && !prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_unexpected: sequence completed with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          $display("seq done @%0t: means %0d %0d %0d %0d %0d", $time,
                   means[0], means[1], means[2], means[3], means[4]);
          for (int p = 0; p < 5; p++)
            check($sformatf("mean_s%0d", p + 1), int'(means[p]), int'(e[16*p +: 16]));
        end
      end
      prev = rst ? bus.end_flag : 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    while (!bus.end_flag && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.end_flag) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: end_flag=0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic wait_rises(input int target);
    int n;
    n = 0;
    while (rise_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (rise_cnt < target) begin
      n_cmp++;
      n_err++;
      $display("FAIL rise_timeout: rise_cnt=%0d, required %0d", rise_cnt, target);
    end
  endtask

  task automatic measure_period(output int n);
    n = 0;
    while (bus.adc_clk && n < 100) begin @(negedge clk); n++; end
    while (!bus.adc_clk && n < 100) begin @(negedge clk); end
    n = 0;
    do begin @(negedge clk); n++; end while (bus.adc_clk && n < 100);
    do begin @(negedge clk); n++; end while (!bus.adc_clk && n < 100);
  endtask

  int per;
  int round_exp;

  initial begin
    rst = 1'b0;
    toggle_en = 1'b0;
    alt = 1'b0;
    bn_val = 14'd17;
    bus.we = 1'b1;
    bus.trigger_sel = 4'b0000;
    bus.one_shot = 1'b0;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_adc_clk", int'(bus.adc_clk), 0);
    check("rst_end_flag", int'(bus.end_flag), 0);
    check("rst_triggers", int'(any_now), 0);
    check("rst_mean_s1", int'(bus.mean_s1), 0);
    check("rst_mean_s5", int'(bus.mean_s5), 0);

    // Constant input, continuous mode, no triggers
    push_exp(17);
    push_exp(17);
    @(negedge clk);
    rst = 1'b1;
    measure_period(per);
    check("adc_clk_period", per, 8);
    wait_end("cont1");
    check("cont1_strobes", rise_cnt, 120);
    @(negedge clk);
    check("end_pulse_width", int'(bus.end_flag), 0);
    wait_end("cont2");
    check("cont2_strobes", rise_cnt, 240);
    check("cont_no_triggers", any_cycles, 0);
    repeat (4) @(negedge clk);

    // Trigger pattern, one-shot, mask change mid-sequence ignored
    bus.trigger_sel = 4'b0101;
    bus.one_shot = 1'b1;
    push_exp(17);
    do_reset();
    wait_rises(10);
    bus.trigger_sel = 4'b1010;
    wait_end("trig");
    check("trig_vdd_cycles", vdd_cycles, 192);
    check("trig_gnd_cycles", gnd_cycles, 192);
    check("trig_vdd_to_gnd", first_gnd - first_vdd, 384);
    check("trig_bad_cycles", bad_cycles, 0);
    repeat (30) @(negedge clk);
    check("oneshot_end_held", int'(bus.end_flag), 1);
    check("done_triggers_off", int'(any_now), 0);

    // Alternating 100/101 averaging
`ifdef ADC_MEAN_ROUND_EN
    round_exp = 101;
`else
    round_exp = 100;
`endif
    bus.trigger_sel = 4'b0000;
    toggle_en = 1'b1;
    push_exp(round_exp);
    do_reset();
    wait_end("alt");
    repeat (3) @(negedge clk);
    toggle_en = 1'b0;

    // Full-scale and zero codes
    bn_val = 14'd16383;
    push_exp(16383);
    do_reset();
    wait_end("max");
    repeat (3) @(negedge clk);
    bn_val = 14'd0;
    push_exp(0);
    do_reset();
    wait_end("zero");
    repeat (3) @(negedge clk);

    // we gating: drop we for 40 clk in phase 3 ACCUM (5 strobes missed)
    bn_val = 14'd17;
    push_exp(17);
    do_reset();
    wait_rises(60);
    repeat (2) @(negedge clk);
    bus.we = 1'b0;
    repeat (40) @(negedge clk);
    bus.we = 1'b1;
    wait_end("we_gate");
    check("we_gate_strobes", rise_cnt, 125);
    repeat (3) @(negedge clk);

    // Reset mid-sequence during phase 4, then a fresh sequence
    bus.trigger_sel = 4'b1111;
    bus.one_shot = 1'b0;
    push_exp(17);
    do_reset();
    wait_end("pre_abort");
    begin
      int n = 0;
      while (!bus.trigger_gnd_0 && n < 2000) begin @(negedge clk); n++; end
      check("abort_reached_phase4", int'(bus.trigger_gnd_0), 1);
    end
    #2 rst = 1'b0;
    #1;
    check("abort_adc_clk", int'(bus.adc_clk), 0);
    check("abort_triggers", int'(any_now), 0);
    check("abort_end_flag", int'(bus.end_flag), 0);
    check("abort_mean_s1", int'(bus.mean_s1), 0);
    check("abort_mean_s3", int'(bus.mean_s3), 0);
    bn_val = 14'd55;
    bus.one_shot = 1'b1;
    push_exp(55);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_end("fresh");
    check("fresh_strobes", rise_cnt, 120);
    repeat (5) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
